// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, legal parameter ranges and
// a frame-format record that a matching transmitter can reuse.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_t;

  localparam int MIN_CLKS_PER_BIT = 4;
  localparam int MIN_DATA_BITS    = 5;
  localparam int MAX_DATA_BITS    = 9;

  typedef struct packed {
    logic [15:0] clks_per_bit;
    logic [3:0]  data_bits;
    logic        parity_en;
    logic        parity_odd;
  } uart_cfg_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: flags the half-bit point (start-bit qualification) and
// the full-bit point (every later sample). Wraps on its own at the full-bit point.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic mid,
  output logic tick
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] MID_CNT  = W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [W-1:0] TICK_CNT = W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_bad_period
    $error("uart_bit_timer: CLKS_PER_BIT below minimum");
  end

  logic [W-1:0] count_q, count_d;

  assign mid  = (count_q == MID_CNT);
  assign tick = (count_q == TICK_CNT);

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = tick ? '0 : count_q + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_stream.sv
// Parametrised UART receiver with synchroniser, glitch rejection, framing check
// and a one-word valid/ready holding register. Define UART_RX_PARITY_EN for parity.
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx_pin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx_stream: DATA_BITS or PARITY_ODD out of range");
  end

  logic [1:0]           sync_q, sync_d;
  logic                 rx_s;
  uart_rx_state_t       state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 deliver;
  logic                 mid, tick, timer_clear;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q, parity_err_d;
`endif

  assign rx_s = sync_q[1];

  // Every state entry restarts the bit period; IDLE holds the timer at zero.
  assign timer_clear = (state_d != state_q) || (state_q == IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clock (clock),
    .reset (reset),
    .clear (timer_clear),
    .enable(1'b1),
    .mid   (mid),
    .tick  (tick)
  );

  always_comb begin
    sync_d      = {sync_q[0], rx_pin};
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    deliver     = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: if (!rx_s) state_d = START;

      START: if (mid) begin
        bit_cnt_d = '0;
        state_d   = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
      end

      DATA: if (tick) begin
        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + BCW'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        par_bad_d = rx_s ^ (^shift_q) ^ 1'(PARITY_ODD);
        state_d   = STOP;
      end
`endif

      STOP: if (tick) begin
        frame_err_d = !rx_s;
        state_d     = rx_s ? IDLE : BREAK;
`ifdef UART_RX_PARITY_EN
        parity_err_d = par_bad_q;
        deliver      = rx_s && !par_bad_q;
`else
        deliver      = rx_s;
`endif
      end

      BREAK: if (rx_s) state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // A full holding register only takes a new word if it is drained this cycle.
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q      <= 2'b11;
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench for uart_rx_stream with a word scoreboard; a monitor pops the
// expected word on every accepted transfer and tallies the pulse outputs.
module tb_uart_rx_stream;
  import uart_pkg::*;

  localparam int CPB  = 16;
  localparam int DB   = 8;
  localparam int PODD = 0;

  logic          clock = 1'b0;
  logic          reset;
  logic          rx_pin;
  logic          rx_ready;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;

  int checks   = 0;
  int failures = 0;

  logic [DB-1:0] exp_q[$];
  int cyc = 0, start_cyc = 0, last_lat = -1, exp_lat;
  int valid_cycles = 0, fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, pop_cnt = 0;
  int v0, f0, p0, o0, q0;
  logic valid_prev = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  uart_rx_stream #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .PARITY_ODD  (PODD)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_pin    (rx_pin),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (rx_valid && !valid_prev) last_lat = cyc - start_cyc;
    valid_prev = rx_valid;
    if (rx_valid)   valid_cycles++;
    if (frame_err)  fe_cnt++;
    if (parity_err) pe_cnt++;
    if (overrun)    ov_cnt++;
    if (rx_valid && rx_ready) begin
      check("sb_word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        pop_cnt++;
      end
    end
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic snapshot();
    v0 = valid_cycles; f0 = fe_cnt; p0 = pe_cnt; o0 = ov_cnt; q0 = pop_cnt;
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_b,
                            input bit deliver, input bit par_flip);
    if (deliver) exp_q.push_back(d);
    @(negedge clock);
    rx_pin    = 1'b0;
    start_cyc = cyc;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < DB; i++) begin
      rx_pin = d[i];
      repeat (CPB) @(negedge clock);
    end
`ifdef UART_RX_PARITY_EN
    rx_pin = (^d) ^ 1'(PODD) ^ par_flip;
    repeat (CPB) @(negedge clock);
`endif
    rx_pin = stop_b;
    repeat (CPB) @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DB-1:0] abort_word;
    exp_lat = (3 * CPB) / 2 + DB * CPB + 3;
`ifdef UART_RX_PARITY_EN
    exp_lat = exp_lat + CPB;
`endif

    // Reset values
    reset = 1'b0; rx_pin = 1'b1; rx_ready = 1'b1;
    #23;
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    check("reset_flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
    check("reset_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clock); reset = 1'b1;
    settle(5);

    // Frame 0xA5: one valid cycle, no flags, latency within one clock of formula
    snapshot();
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    settle(20);
    check("a5_valid_cycles", 32'(valid_cycles - v0), 32'd1);
    check("a5_popped", 32'(pop_cnt - q0), 32'd1);
    check("a5_flags", 32'((fe_cnt - f0) + (pe_cnt - p0) + (ov_cnt - o0)), 32'd0);
    check("a5_latency",
          32'((last_lat >= exp_lat - 1 && last_lat <= exp_lat + 1) ? exp_lat : last_lat),
          32'(exp_lat));

    // 6-clock glitch on idle line
    snapshot();
    @(negedge clock); rx_pin = 1'b0;
    repeat (6) @(negedge clock);
    rx_pin = 1'b1;
    settle(3 * CPB);
    check("glitch_state", 32'(dut.state_q), 32'(IDLE));
    check("glitch_valid", 32'(valid_cycles - v0), 32'd0);
    check("glitch_flags", 32'((fe_cnt - f0) + (pe_cnt - p0)), 32'd0);

    // Low stop bit, line held low: one frame_err, then normal frame
    snapshot();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    rx_pin = 1'b0;
    repeat (40 * CPB) @(negedge clock);
    rx_pin = 1'b1;
    settle(2 * CPB);
    check("break_frame_err", 32'(fe_cnt - f0), 32'd1);
    check("break_no_valid", 32'(valid_cycles - v0), 32'd0);
    check("break_state", 32'(dut.state_q), 32'(IDLE));
    snapshot();
    send_frame(8'h12, 1'b1, 1'b1, 1'b0);
    settle(20);
    check("after_break_popped", 32'(pop_cnt - q0), 32'd1);
    check("after_break_flags", 32'(fe_cnt - f0), 32'd0);

    // Overrun: two back-to-back words while stalled
    rx_ready = 1'b0;
    snapshot();
    send_frame(8'h11, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    settle(20);
    check("ovr_valid_held", 32'(rx_valid), 32'd1);
    check("ovr_data_held", 32'(rx_data), 32'h11);
    check("ovr_pulses", 32'(ov_cnt - o0), 32'd1);
    @(negedge clock); rx_ready = 1'b1;
    settle(3);
    check("ovr_drained_valid", 32'(rx_valid), 32'd0);
    check("ovr_drained_pop", 32'(pop_cnt - q0), 32'd1);
    check("ovr_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset in bit 4 of a frame with a word pending
    rx_ready = 1'b0;
    send_frame(8'h55, 1'b1, 1'b1, 1'b0);
    settle(5);
    check("pre_reset_valid", 32'(rx_valid), 32'd1);
    check("pre_reset_data", 32'(rx_data), 32'h55);
    abort_word = 8'h99;
    @(negedge clock); rx_pin = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      rx_pin = abort_word[i];
      repeat (CPB) @(negedge clock);
    end
    rx_pin = abort_word[4];
    repeat (CPB / 2) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("mid_reset_valid", 32'(rx_valid), 32'd0);
    check("mid_reset_data", 32'(rx_data), 32'd0);
    check("mid_reset_flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
    exp_q.delete();
    rx_pin = 1'b1; rx_ready = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    settle(5);
    check("post_reset_state", 32'(dut.state_q), 32'(IDLE));
    snapshot();
    send_frame(8'h7E, 1'b1, 1'b1, 1'b0);
    settle(20);
    check("post_reset_popped", 32'(pop_cnt - q0), 32'd1);
    check("post_reset_flags", 32'((fe_cnt - f0) + (ov_cnt - o0)), 32'd0);

`ifdef UART_RX_PARITY_EN
    // Even parity: good parity delivered, flipped parity flagged and dropped
    snapshot();
    send_frame(8'h03, 1'b1, 1'b1, 1'b0);
    send_frame(8'h03, 1'b1, 1'b0, 1'b1);
    settle(20);
    check("par_err_pulses", 32'(pe_cnt - p0), 32'd1);
    check("par_valid_cycles", 32'(valid_cycles - v0), 32'd1);
    check("par_popped", 32'(pop_cnt - q0), 32'd1);
    check("par_no_frame_err", 32'(fe_cnt - f0), 32'd0);
`endif

    check("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
